// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: read-domain bundle linking the read controller, fifo_mem read port and the consumer.
// master is the controller side, slave is the memory/consumer side.
interface fifo_rd_ctrl_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    logic [ASIZE:0]   rq2_wptr;
    logic [DSIZE-1:0] rdata_mem;
    logic             rready;
    logic [ASIZE:0]   rptr;
    logic [ASIZE-1:0] raddr;
    logic             rclken;
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rvalid;
    logic             ralmost_empty;
    modport master (
        input  rq2_wptr, rdata_mem, rready,
        output rptr, raddr, rclken, rempty, rdata, rvalid, ralmost_empty
    );
    modport slave (
        output rq2_wptr, rdata_mem, rready,
        input  rptr, raddr, rclken, rempty, rdata, rvalid, ralmost_empty
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side dual-clock FIFO controller with Gray pointer, registered empty and FWFT valid/ready output.
// Optional registered almost-empty flag is built when FIFO_RALMOST_EMPTY_EN is defined.
module fifo_rd_ctrl #(
    parameter int DSIZE    = 8,
    parameter int ASIZE    = 4,
    parameter int AE_LEVEL = 2
) (
    input logic            rclk,
    input logic            rrst,
    fifo_rd_ctrl_if.master rd
);
    logic [ASIZE:0] rbin_q, rbin_d, rptr_q, rptr_d;
    logic           rempty_q, rempty_d, rvalid_q, rvalid_d, rclken;
    // A read is issued whenever a word is available and the output slot is free or being drained.
    always_comb begin
        rclken   = ~rempty_q & (~rvalid_q | rd.rready) & ~rrst;
        rbin_d   = rbin_q + (ASIZE+1)'(rclken);
        rptr_d   = (rbin_d >> 1) ^ rbin_d;
        rempty_d = rptr_d == rd.rq2_wptr;
        rvalid_d = rclken ? 1'b1 : rd.rready ? 1'b0 : rvalid_q;
    end
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            rempty_q <= 1'b1;
            rvalid_q <= 1'b0;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rptr_d;
            rempty_q <= rempty_d;
            rvalid_q <= rvalid_d;
        end
    end
    assign rd.rptr   = rptr_q;
    assign rd.raddr  = rbin_q[ASIZE-1:0];
    assign rd.rclken = rclken;
    assign rd.rempty = rempty_q;
    assign rd.rvalid = rvalid_q;
    assign rd.rdata  = DSIZE'(rd.rdata_mem);
`ifdef FIFO_RALMOST_EMPTY_EN
    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
    logic ralmost_empty_q, ralmost_empty_d;
    // Counts words still in memory; the word held on rdata is excluded.
    assign ralmost_empty_d = (gray2bin(rd.rq2_wptr) - rbin_d) <= (ASIZE+1)'(AE_LEVEL);
    always_ff @(posedge rclk) ralmost_empty_q <= rrst | ralmost_empty_d;
    assign rd.ralmost_empty = ralmost_empty_q;
`else
    assign rd.ralmost_empty = 1'b0;
`endif
endmodule
